// File: rtl/nios2_ocimem_ctrl.sv
// nios2_ocimem_ctrl: OCI debug RAM shared by JTAG debug strobes and the CPU Avalon-MM slave port.
// Define OCIMEM_DEBUGACK_GATE_EN to drop JTAG writes (and flag jtag_wr_err) while debugack is low.
module nios2_ocimem_ctrl #(
    parameter int    ADDR_W    = 8,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              debugack,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_chipselect,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [31:0]       av_writedata,
    input  logic [3:0]        av_byteenable,
    output logic [31:0]       av_readdata,
    output logic              av_waitrequest,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] jtag_addr,
    output logic              jtag_wr_err
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, AV_RD} state_t;

    state_t            state_q, state_d;
    logic [31:0]       mem [DEPTH];
    logic [31:0]       ram_q, ram_wdata;
    logic [ADDR_W-1:0] ram_addr, jtag_addr_q, jtag_addr_d;
    logic [31:0]       mon_q, mon_d, rdata_q, rdata_d;
    logic [3:0]        ram_be;
    logic              ram_we, ram_re, jrd_q, jrd_d, err_q, err_d;
    logic              st_a, st_b, st_n, jtag_hit, av_req, wr_ok, unused_ok;

`ifdef OCIMEM_DEBUGACK_GATE_EN
    assign wr_ok     = debugack;
    assign unused_ok = ^{jdo[37:36], jdo[2:0]};
`else
    assign wr_ok     = 1'b1;
    assign unused_ok = ^{jdo[37:36], jdo[2:0], debugack};
`endif

    assign st_a        = take_action_ocimem_a;
    assign st_b        = take_action_ocimem_b & ~st_a;
    assign st_n        = take_no_action_ocimem_a & ~st_a & ~take_action_ocimem_b;
    assign jtag_hit    = st_a | st_b | st_n;
    assign av_req      = av_chipselect & (av_read | av_write);
    assign av_readdata = rdata_q;
    assign MonDReg     = mon_q;
    assign jtag_addr   = jtag_addr_q;
    assign jtag_wr_err = err_q;

    // JTAG owns the RAM port whenever it strobes; Avalon only gets it in IDLE.
    always_comb begin
        state_d        = state_q;
        jtag_addr_d    = jtag_addr_q;
        ram_addr       = jtag_addr_q;
        ram_we         = 1'b0;
        ram_re         = 1'b0;
        ram_be         = 4'hf;
        ram_wdata      = jdo[34:3];
        jrd_d          = 1'b0;
        rdata_d        = rdata_q;
        mon_d          = jrd_q ? ram_q : mon_q;
        err_d          = err_q;
        av_waitrequest = av_req;
        if (st_a) begin
            jtag_addr_d = jdo[ADDR_W+9:10];
            ram_addr    = jdo[ADDR_W+9:10];
            ram_re      = jdo[35];
            jrd_d       = jdo[35];
            err_d       = 1'b0;
        end else if (st_b) begin
            ram_we      = wr_ok;
            jtag_addr_d = wr_ok ? jtag_addr_q + ADDR_W'(1) : jtag_addr_q;
            err_d       = err_q | ~wr_ok;
        end else if (st_n) begin
            ram_re      = 1'b1;
            jrd_d       = 1'b1;
            jtag_addr_d = jtag_addr_q + ADDR_W'(1);
        end
        if (state_q == AV_RD) begin
            rdata_d        = ram_q;
            av_waitrequest = 1'b0;
            state_d        = IDLE;
        end else if (av_req && !jtag_hit) begin
            ram_addr  = av_address;
            ram_be    = av_byteenable;
            ram_wdata = av_writedata;
            if (av_read) begin
                ram_re  = 1'b1;
                state_d = AV_RD;
            end else begin
                ram_we         = 1'b1;
                av_waitrequest = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            jtag_addr_q <= '0;
            mon_q       <= '0;
            rdata_q     <= '0;
            jrd_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            jtag_addr_q <= jtag_addr_d;
            mon_q       <= mon_d;
            rdata_q     <= rdata_d;
            jrd_q       <= jrd_d;
            err_q       <= err_d;
        end
    end

    // Storage is never reset; a read during a write cannot occur on this single port.
    always @(posedge clk) begin
        if (ram_we)
            for (int i = 0; i < 4; i++)
                if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        if (ram_re) ram_q <= mem[ram_addr];
    end
endmodule

// File: tb/tb_nios2_ocimem_ctrl.sv
// tb_nios2_ocimem_ctrl: directed bench with a transaction-level memory model checked every cycle.
module tb_nios2_ocimem_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        ta_a = 1'b0, ta_b = 1'b0, tn = 1'b0, debugack = 1'b1;
    logic [7:0]  av_address = '0;
    logic        av_chipselect = 1'b0, av_read = 1'b0, av_write = 1'b0;
    logic [31:0] av_writedata = '0;
    logic [3:0]  av_byteenable = '0;
    logic [31:0] av_readdata, MonDReg;
    logic        av_waitrequest, jtag_wr_err;
    logic [7:0]  jtag_addr;

    int n_chk = 0, n_fail = 0;
    bit run = 1'b0;

    logic [31:0] m_mem [256];
    logic [7:0]  m_addr = '0;
    logic [31:0] m_mon = '0, m_rdata = '0, pend_val = '0, av_val = '0;
    bit          m_err = 1'b0, pend = 1'b0, av_ph = 1'b0;
    int          waits;

    nios2_ocimem_ctrl #(.ADDR_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b),
        .take_no_action_ocimem_a(tn), .debugack(debugack),
        .av_address(av_address), .av_chipselect(av_chipselect), .av_read(av_read),
        .av_write(av_write), .av_writedata(av_writedata), .av_byteenable(av_byteenable),
        .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
        .MonDReg(MonDReg), .jtag_addr(jtag_addr), .jtag_wr_err(jtag_wr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Spec-level view: JTAG read data surfaces one edge after the access, Avalon read data likewise.
    initial forever begin
        @(posedge clk);
        if (run) begin
            bit a, b, n, req, wok;
            a   = ta_a;
            b   = ta_b && !a;
            n   = tn && !a && !ta_b;
            req = av_chipselect && (av_read || av_write);
`ifdef OCIMEM_DEBUGACK_GATE_EN
            wok = debugack;
`else
            wok = 1'b1;
`endif
            if (pend) m_mon = pend_val;
            pend = 1'b0;
            if (av_ph) begin
                m_rdata = av_val;
                av_ph = 1'b0;
            end else if (req && !(a || b || n)) begin
                if (av_read) begin
                    av_val = m_mem[av_address];
                    av_ph = 1'b1;
                end else
                    for (int k = 0; k < 4; k++)
                        if (av_byteenable[k]) m_mem[av_address][8*k +: 8] = av_writedata[8*k +: 8];
            end
            if (a) begin
                m_addr = jdo[17:10];
                m_err = 1'b0;
                if (jdo[35]) begin
                    pend = 1'b1;
                    pend_val = m_mem[m_addr];
                end
            end else if (b) begin
                if (wok) begin
                    m_mem[m_addr] = jdo[34:3];
                    m_addr = m_addr + 8'd1;
                end else m_err = 1'b1;
            end else if (n) begin
                pend = 1'b1;
                pend_val = m_mem[m_addr];
                m_addr = m_addr + 8'd1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (run) begin
            bit req, any, exp_wait;
            req = av_chipselect && (av_read || av_write);
            any = ta_a || ta_b || tn;
            exp_wait = req && !(av_ph || (!any && !av_read));
            chk("cyc MonDReg", MonDReg, m_mon);
            chk("cyc jtag_addr", {24'd0, jtag_addr}, {24'd0, m_addr});
            chk("cyc jtag_wr_err", {31'd0, jtag_wr_err}, {31'd0, m_err});
            chk("cyc av_readdata", av_readdata, m_rdata);
            chk("cyc av_waitrequest", {31'd0, av_waitrequest}, {31'd0, exp_wait});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_a(input logic [7:0] a, input logic rd);
        jdo = '0;
        jdo[17:10] = a;
        jdo[35] = rd;
        ta_a = 1'b1;
        cyc();
        ta_a = 1'b0;
        jdo = '0;
    endtask

    task automatic strobe_b(input logic [31:0] d);
        jdo = '0;
        jdo[34:3] = d;
        ta_b = 1'b1;
        cyc();
        ta_b = 1'b0;
        jdo = '0;
    endtask

    task automatic strobe_n();
        tn = 1'b1;
        cyc();
        tn = 1'b0;
    endtask

    task automatic av_op(input bit is_wr, input logic [7:0] adr, input logic [31:0] d,
                         input logic [3:0] be, input bit with_n, output int w);
        bit done;
        done = 1'b0;
        w = 0;
        av_chipselect = 1'b1;
        av_read = !is_wr;
        av_write = is_wr;
        av_address = adr;
        av_writedata = d;
        av_byteenable = be;
        tn = with_n;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (!av_waitrequest) done = 1'b1;
            else begin
                w++;
                cyc();
                tn = 1'b0;
            end
        end
        if (!done) chk("avalon timeout", 32'd1, 32'd0);
        cyc();
        av_chipselect = 1'b0;
        av_read = 1'b0;
        av_write = 1'b0;
        tn = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 256; k++) m_mem[k] = '0;
        repeat (3) cyc();
        chk("reset MonDReg", MonDReg, 32'h0);
        chk("reset jtag_addr", {24'd0, jtag_addr}, 32'h0);
        chk("reset av_readdata", av_readdata, 32'h0);
        chk("reset waitrequest", {31'd0, av_waitrequest}, 32'h0);
        reset_n = 1'b1;
        run = 1'b1;
        cyc();

        strobe_a(8'h10, 1'b0);
        chk("load addr", {24'd0, jtag_addr}, 32'h10);
        strobe_b(32'hDEADBEEF);
        chk("addr after write", {24'd0, jtag_addr}, 32'h11);
        strobe_a(8'h10, 1'b1);
        cyc();
        chk("jtag read-on-load", MonDReg, 32'hDEADBEEF);
        chk("addr after read-on-load", {24'd0, jtag_addr}, 32'h10);

        av_op(1'b1, 8'h20, 32'hFFFFFFFF, 4'hF, 1'b0, waits);
        chk("av write waits", waits, 0);
        av_op(1'b1, 8'h20, 32'h12345678, 4'h3, 1'b0, waits);
        chk("av partial write waits", waits, 0);
        av_op(1'b0, 8'h20, 32'h0, 4'hF, 1'b0, waits);
        chk("av read waits", waits, 1);
        chk("av read data", av_readdata, 32'hFFFF5678);

        av_op(1'b0, 8'h20, 32'h0, 4'hF, 1'b1, waits);
        chk("contended read waits", waits, 2);
        chk("contended MonDReg", MonDReg, 32'hDEADBEEF);
        chk("contended av data", av_readdata, 32'hFFFF5678);
        chk("contended jtag_addr", {24'd0, jtag_addr}, 32'h11);

        strobe_a(8'hFF, 1'b0);
        strobe_b(32'hA5A50001);
        strobe_b(32'h5A5A0002);
        chk("wrap on write", {24'd0, jtag_addr}, 32'h01);
        strobe_a(8'hFF, 1'b0);
        strobe_n();
        strobe_n();
        chk("first read 0xFF", MonDReg, 32'hA5A50001);
        cyc();
        chk("second read 0x00", MonDReg, 32'h5A5A0002);
        chk("wrap on read", {24'd0, jtag_addr}, 32'h01);

        jdo = '0;
        jdo[17:10] = 8'h40;
        ta_a = 1'b1;
        ta_b = 1'b1;
        tn = 1'b1;
        cyc();
        ta_a = 1'b0;
        ta_b = 1'b0;
        tn = 1'b0;
        jdo = '0;
        chk("priority a wins", {24'd0, jtag_addr}, 32'h40);

        strobe_a(8'h30, 1'b0);
        strobe_b(32'h11111111);
        strobe_a(8'h30, 1'b0);
        debugack = 1'b0;
        strobe_b(32'h22222222);
        debugack = 1'b1;
`ifdef OCIMEM_DEBUGACK_GATE_EN
        chk("gated addr hold", {24'd0, jtag_addr}, 32'h30);
        chk("gated err set", {31'd0, jtag_wr_err}, 32'h1);
`else
        chk("ungated addr inc", {24'd0, jtag_addr}, 32'h31);
        chk("ungated err low", {31'd0, jtag_wr_err}, 32'h0);
`endif
        strobe_a(8'h30, 1'b1);
        cyc();
        chk("err cleared by load", {31'd0, jtag_wr_err}, 32'h0);
`ifdef OCIMEM_DEBUGACK_GATE_EN
        chk("gated ram unchanged", MonDReg, 32'h11111111);
`else
        chk("ungated ram written", MonDReg, 32'h22222222);
`endif
        repeat (2) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
